booth_stream_if: RTL and testbench

//  Valid/ready wrapper for the free-running 233x233 sequential Booth core.
//  - Input side: accepts signed operand pairs. Holds them stable for the core's 234-cycle period.
//  - Core side: drives the core's sync active-high reset. Mirrors its iteration counter.
//  - Output side: captures each real product into a 2-entry output FIFO.

---
 rtl/booth_stream_if.sv | 143 ++++++++++++++
 tb/tb_booth_stream_if.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_stream_if.sv
// booth_stream_if: valid/ready wrapper around a free-running WIDTHxWIDTH sequential Booth core.
// Accepts signed operand pairs, holds them on core_a/core_b for a full core period and
// captures each real product from core_c into a 2-entry output FIFO.
//
// Ports:
//   clk        in   clock
//   rst        in   asynchronous active-low reset
//   in_valid   in   operand pair valid
//   in_ready   out  operand pair accepted on in_valid && in_ready at a clk edge
//   in_a/in_b  in   signed multiplicand / multiplier
//   out_valid  out  FIFO head valid
//   out_ready  in   consumer pops the head on out_valid && out_ready
//   out_c      out  signed product (FIFO head)
//   core_rst   out  core synchronous active-high reset
//   core_a/b   out  operands held for the core
//   core_c     in   core product
module booth_stream_if #(
    parameter int unsigned WIDTH = 233,
    parameter int unsigned CW    = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_c,
    output logic               core_rst,
    output logic [WIDTH-1:0]   core_a,
    output logic [WIDTH-1:0]   core_b,
    input  logic [2*WIDTH-1:0] core_c
);

    localparam logic [CW-1:0] CntMax = CW'(WIDTH);
    localparam logic [CW-1:0] CntOne = CW'(1);

    logic [CW-1:0]        cnt;
    logic                 buf_v;
    logic                 hold_v;
    logic                 run_v;
    logic [WIDTH-1:0]     buf_a;
    logic [WIDTH-1:0]     buf_b;
    logic [2*WIDTH-1:0]   fifo_mem [2];
    logic                 fifo_wr;
    logic                 fifo_rd;
    logic [1:0]           fifo_cnt;

    logic in_fire;
    logic out_fire;
    logic phase_load;
    logic phase_end;
    logic load_ok;
    logic load_buf;
    logic load_byp;
    logic push;

    always_comb begin
        in_ready   = !buf_v && !core_rst;
        in_fire    = in_valid && in_ready;
        out_valid  = (fifo_cnt != 2'd0);
        out_fire   = out_valid && out_ready;
        out_c      = fifo_mem[fifo_rd];
        phase_load = !core_rst && (cnt == CntOne);
        phase_end  = !core_rst && (cnt == '0);
        // Credit check ignores a same-cycle pop, so a started job always finds a free slot.
        load_ok    = phase_load && (({1'b0, fifo_cnt} + {2'b00, run_v}) < 3'd2);
        load_buf   = load_ok && buf_v;
        load_byp   = load_ok && !buf_v && in_fire;
        push       = phase_end && run_v;
    end

    // Core reset and phase counter; cnt tracks the core's own iteration counter exactly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            core_rst <= 1'b1;
            cnt      <= '0;
        end else begin
            core_rst <= 1'b0;
            if (!core_rst) begin
                cnt <= (cnt == '0) ? CntMax : cnt - CntOne;
            end
        end
    end

    // Operand buffer, core operand hold and job-valid pipeline (hold_v -> run_v).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_v  <= 1'b0;
            buf_a  <= '0;
            buf_b  <= '0;
            hold_v <= 1'b0;
            run_v  <= 1'b0;
            core_a <= '0;
            core_b <= '0;
        end else begin
            if (load_buf) begin
                core_a <= buf_a;
                core_b <= buf_b;
                buf_v  <= 1'b0;
            end else if (load_byp) begin
                core_a <= in_a;
                core_b <= in_b;
            end
            if (phase_load) begin
                hold_v <= load_buf || load_byp;
            end
            // in_fire needs an empty buffer, so it never collides with load_buf.
            if (in_fire && !load_byp) begin
                buf_a <= in_a;
                buf_b <= in_b;
                buf_v <= 1'b1;
            end
            if (phase_end) begin
                run_v <= hold_v;
            end
        end
    end

    // 2-entry output FIFO.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fifo_mem <= '{default: '0};
            fifo_wr  <= 1'b0;
            fifo_rd  <= 1'b0;
            fifo_cnt <= 2'd0;
        end else begin
            if (push) begin
                fifo_mem[fifo_wr] <= core_c;
                fifo_wr           <= !fifo_wr;
            end
            if (out_fire) begin
                fifo_rd <= !fifo_rd;
            end
            fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, out_fire};
        end
    end

    no_push_on_full: assert property (@(posedge clk) disable iff (!rst)
        !(push && (fifo_cnt == 2'd2)));

endmodule

// File: tb/tb_booth_stream_if.sv
// tb_booth_stream_if: self-checking bench for booth_stream_if.
// Contains a behavioural Booth core (one product per period, visible only in the cycle before
// the capture edge) and a product scoreboard driven from plain signed multiplication.
module tb_booth_stream_if;

    localparam int unsigned Width  = 233;
    localparam int unsigned Period = Width + 1;
    localparam int unsigned NRand  = 80;

    typedef logic [2*Width-1:0] prod_t;

    localparam logic [Width-1:0] MinOp = {1'b1, {(Width-1){1'b0}}};
    localparam logic [Width-1:0] MaxOp = {1'b0, {(Width-1){1'b1}}};

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [Width-1:0] in_a = '0;
    logic [Width-1:0] in_b = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    prod_t            out_c;
    logic             core_rst;
    logic [Width-1:0] core_a;
    logic [Width-1:0] core_b;
    prod_t            core_c = '0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    booth_stream_if #(
        .WIDTH(Width),
        .CW   (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_c    (out_c),
        .core_rst (core_rst),
        .core_a   (core_a),
        .core_b   (core_b),
        .core_c   (core_c)
    );

    task automatic check(input string tag, input prod_t got, input prod_t exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic prod_t smul(input logic [Width-1:0] a, input logic [Width-1:0] b);
        logic signed [2*Width-1:0] sa;
        logic signed [2*Width-1:0] sb;
        sa = {{Width{a[Width-1]}}, a};
        sb = {{Width{b[Width-1]}}, b};
        return prod_t'(sa * sb);
    endfunction

    function automatic logic [Width-1:0] rand_op();
        logic [255:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) r = {r[223:0], $urandom()};
        case ($urandom_range(0, 7))
            0:       return MinOp;
            1:       return MaxOp;
            2:       return '0;
            3:       return '1;
            default: return r[Width-1:0];
        endcase
    endfunction

    function automatic logic [Width-1:0] neg(input logic [Width-1:0] x);
        return ~x + 1'b1;
    endfunction

    // Cycles from the accepting edge to out_valid rising, for a pair accepted at core phase p
    // into an idle wrapper: wait for the next phase-1 edge, then one full period plus one.
    function automatic int unsigned lat_model(input int unsigned p);
        return ((p == 0) ? Width : p - 1) + Period + 1;
    endfunction

    // Behavioural core: its own iteration counter, starts a job at phase 0, product appears
    // at the phase-1 edge and is replaced by garbage at the following phase-0 edge.
    int unsigned ccnt = 0;
    int unsigned last_edge_ph = 0;
    prod_t       pend = '0;
    always @(posedge clk) begin
        last_edge_ph <= ccnt;
        if (core_rst) begin
            ccnt <= 0;
        end else begin
            ccnt <= (ccnt == 0) ? Width : ccnt - 1;
            if (ccnt == 0) begin
                pend   <= smul(core_a, core_b);
                core_c <= {rand_op(), rand_op()};
            end
            if (ccnt == 1) core_c <= pend;
        end
    end

    // Core operands may only move on an edge that had phase 1 before it.
    logic [Width-1:0] prev_a = '0;
    logic [Width-1:0] prev_b = '0;
    always @(negedge clk) begin
        if (rst && !core_rst && (core_a !== prev_a || core_b !== prev_b))
            check("core_ab_change_phase", prod_t'(last_edge_ph), prod_t'(1));
        prev_a <= core_a;
        prev_b <= core_b;
    end

    // Monitor and scoreboard.
    int unsigned cyc = 0;
    int unsigned acc_cyc = 0;
    int unsigned acc_ph = 0;
    int unsigned rise_cyc = 0;
    int unsigned n_acc = 0;
    int unsigned n_rise = 0;
    int unsigned n_pop = 0;
    logic        ov_prev = 1'b0;
    prod_t       exp_q[$];
    prod_t       out_hist[$];
    int unsigned pop_cyc[$];
    always @(posedge clk) begin
        cyc     <= cyc + 1;
        ov_prev <= out_valid;
        if (rst) begin
            if (in_valid && in_ready) begin
                exp_q.push_back(smul(in_a, in_b));
                acc_cyc <= cyc;
                acc_ph  <= ccnt;
                n_acc   <= n_acc + 1;
            end
            if (out_valid && !ov_prev) begin
                rise_cyc <= cyc - 1;
                n_rise   <= n_rise + 1;
            end
            if (out_valid && out_ready) begin
                check("product_expected", prod_t'(exp_q.size() != 0), prod_t'(1));
                if (exp_q.size() != 0) check("product", out_c, exp_q.pop_front());
                out_hist.push_back(out_c);
                pop_cyc.push_back(cyc);
                n_pop <= n_pop + 1;
            end
        end
    end

    // Called and returns at a negedge.
    task automatic send(input logic [Width-1:0] a, input logic [Width-1:0] b);
        int unsigned n = 0;
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        while (!in_ready && n < 6 * Period) begin
            @(negedge clk);
            n++;
        end
        check("send_ready", prod_t'(in_ready), prod_t'(1));
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_phase(input int unsigned ph);
        int unsigned n = 0;
        @(negedge clk);
        while (ccnt != ph && n < 2 * Period) begin
            @(negedge clk);
            n++;
        end
        check("wait_phase", prod_t'(ccnt), prod_t'(ph));
    endtask

    task automatic wait_pops(input string tag, input int unsigned target);
        int unsigned n = 0;
        while (n_pop < target && n < 5 * Period) begin
            @(negedge clk);
            n++;
        end
        check(tag, prod_t'(n_pop), prod_t'(target));
    endtask

    task automatic wait_rise(input string tag, input int unsigned target);
        int unsigned n = 0;
        while (n_rise < target && n < 4 * Period) begin
            @(negedge clk);
            n++;
        end
        check(tag, prod_t'(n_rise), prod_t'(target));
    endtask

    initial begin
        #(10 * 120000);
        $display("FAIL watchdog: time limit reached after %0d checks", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        prod_t            e;
        int unsigned      base;
        int unsigned      base_acc;
        int unsigned      rbase;
        logic [Width-1:0] a1, b1, a2, b2;
        int unsigned      phs[3];
        bit               done;

        repeat (3) @(negedge clk);
        check("rst_core_rst", prod_t'(core_rst), prod_t'(1));
        check("rst_out_valid", prod_t'(out_valid), prod_t'(0));
        check("rst_in_ready", prod_t'(in_ready), prod_t'(0));
        check("rst_core_a", prod_t'(core_a), prod_t'(0));
        check("rst_core_b", prod_t'(core_b), prod_t'(0));

        // 1: first pair after reset release.
        rst       = 1'b1;
        out_ready = 1'b1;
        send(Width'(3), neg(Width'(5)));
        check("t1_in_ready_after_accept", prod_t'(in_ready), prod_t'(acc_ph == 1));
        wait_rise("t1_rise", 1);
        check("t1_latency", prod_t'(rise_cyc - acc_cyc), prod_t'(lat_model(acc_ph)));
        wait_pops("t1_pops", 1);
        e      = '1;
        e[3:1] = 3'b000;
        if (out_hist.size() >= 1) check("t1_minus15", out_hist[0], e);

        // 2: corner operands back to back.
        out_hist.delete();
        pop_cyc.delete();
        base = n_pop;
        send(MinOp, MinOp);
        send(MaxOp, MinOp);
        send('0, rand_op());
        wait_pops("t2_pops", base + 3);
        if (out_hist.size() >= 3) begin
            e = '0;
            e[2*Width-2] = 1'b1;
            check("t2_min_min", out_hist[0], e);
            e = '0;
            e[2*Width-1] = 1'b1;
            e[2*Width-2] = 1'b1;
            e[Width-1]   = 1'b1;
            check("t2_max_min", out_hist[1], e);
            check("t2_zero", out_hist[2], '0);
            check("t2_spacing_0", prod_t'(pop_cyc[1] - pop_cyc[0]), prod_t'(Period));
            check("t2_spacing_1", prod_t'(pop_cyc[2] - pop_cyc[1]), prod_t'(Period));
        end

        // 3: backpressure with four pairs offered.
        out_ready = 1'b0;
        base      = n_pop;
        base_acc  = n_acc;
        fork
            begin
                for (int i = 0; i < 4; i++) send(rand_op(), rand_op());
            end
        join_none
        repeat (4 * Period) @(negedge clk);
        check("t3_accepted", prod_t'(n_acc - base_acc), prod_t'(3));
        check("t3_out_valid", prod_t'(out_valid), prod_t'(1));
        check("t3_in_ready", prod_t'(in_ready), prod_t'(0));
        check("t3_no_pop", prod_t'(n_pop - base), prod_t'(0));
        out_ready = 1'b1;
        wait fork;
        wait_pops("t3_pops", base + 4);
        check("t3_drained", prod_t'(exp_q.size()), prod_t'(0));

        // 4: handshake phase vs latency.
        phs = '{1, 2, 0};
        foreach (phs[i]) begin
            rbase = n_rise;
            base  = n_pop;
            wait_phase(phs[i]);
            send(rand_op(), rand_op());
            wait_rise("t4_rise", rbase + 1);
            check($sformatf("t4_latency_ph%0d", phs[i]), prod_t'(rise_cyc - acc_cyc),
                  prod_t'(lat_model(phs[i])));
            wait_pops("t4_pops", base + 1);
        end

        // 5: push and pop on the same edge with one entry held.
        out_ready = 1'b0;
        base      = n_pop;
        rbase     = n_rise;
        a1 = rand_op(); b1 = rand_op(); a2 = rand_op(); b2 = rand_op();
        send(a1, b1);
        send(a2, b2);
        wait_rise("t5_first_push", rbase + 1);
        wait_phase(0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("t5_valid_after_swap", prod_t'(out_valid), prod_t'(1));
        check("t5_head_after_swap", out_c, smul(a2, b2));
        check("t5_one_pop", prod_t'(n_pop - base), prod_t'(1));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("t5_empty_after_pop", prod_t'(out_valid), prod_t'(0));
        check("t5_two_pops", prod_t'(n_pop - base), prod_t'(2));

        // 6: asynchronous reset mid-iteration with work in flight.
        rbase = n_rise;
        send(rand_op(), rand_op());
        send(rand_op(), rand_op());
        wait_rise("t6_fifo_loaded", rbase + 1);
        wait_phase(100);
        #2 rst = 1'b0;
        #1;
        check("t6_core_rst", prod_t'(core_rst), prod_t'(1));
        check("t6_out_valid", prod_t'(out_valid), prod_t'(0));
        check("t6_in_ready", prod_t'(in_ready), prod_t'(0));
        check("t6_core_a", prod_t'(core_a), prod_t'(0));
        check("t6_core_b", prod_t'(core_b), prod_t'(0));
        exp_q.delete();
        @(negedge clk);
        rst       = 1'b1;
        out_ready = 1'b1;
        base      = n_pop;
        out_hist.delete();
        send(Width'(7), Width'(6));
        wait_pops("t6_pops", base + 1);
        if (out_hist.size() >= 1) check("t6_42", out_hist[0], prod_t'(42));
        repeat (2 * Period) @(negedge clk);
        check("t6_no_stale", prod_t'(n_pop - base), prod_t'(1));

        // Random pairs with random consumer stalls.
        base = n_pop;
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < NRand; i++) begin
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    send(rand_op(), rand_op());
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(negedge clk);
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        wait_pops("rand_pops", base + NRand);
        check("rand_drained", prod_t'(exp_q.size()), prod_t'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
